// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: access width codes,
// FSM state encoding and the alignment error rule.
package mem_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Width 11 is never legal; halves need even, words need 4-byte alignment.
    function automatic logic misalign_err(input logic [1:0] width,
                                          input logic [1:0] addr_lo);
        logic err;
        case (width)
            W_BYTE:  err = 1'b0;
            W_HALF:  err = addr_lo[0];
            W_WORD:  err = |addr_lo;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data memory
// responder (slave).
interface data_mem_responder_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
);

    logic               i_req_valid;
    logic               o_req_ready;
    logic               i_req_we;
    logic [NB_ADDR-1:0] i_req_addr;
    logic [1:0]         i_req_width;
    logic               i_req_sign;
    logic [NB_DATA-1:0] i_req_wdata;
    logic               o_rsp_valid;
    logic [NB_DATA-1:0] o_rsp_rdata;
    logic               o_rsp_err;

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_width, i_req_sign, i_req_wdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_width, i_req_sign, i_req_wdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte lane steering: byte enables and replicated write data
// for stores, lane extraction with sign/zero extension for loads.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic [1:0]         width,
    input  logic [1:0]         addr_lo,
    input  logic               sign,
    input  logic [NB_DATA-1:0] wdata,
    input  logic [NB_DATA-1:0] rword,
    output logic [3:0]         byte_en,
    output logic [NB_DATA-1:0] wdata_lane,
    output logic [NB_DATA-1:0] rdata_ext
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Narrow store data is replicated to every lane so the enable alone picks the target.
    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = '0;
        rdata_ext  = '0;
        lane_byte  = rword[8*addr_lo +: 8];
        lane_half  = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (width)
            W_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {(NB_DATA/8){wdata[7:0]}};
                rdata_ext  = {{(NB_DATA-8){sign & lane_byte[7]}}, lane_byte};
            end
            W_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {(NB_DATA/16){wdata[15:0]}};
                rdata_ext  = {{(NB_DATA-16){sign & lane_half[15]}}, lane_half};
            end
            W_WORD: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
            default: begin
                byte_en    = 4'b0000;
                wdata_lane = '0;
                rdata_ext  = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MIPS MEM stage: valid/ready requests,
// fixed-latency one-cycle responses with error reporting, and a debug read port.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     i_rst,
    data_mem_responder_if.slave      bus,
    input  logic                     i_dbg_en,
    input  logic [NB_ADDR-3:0]       i_dbg_addr,
    output logic [NB_DATA-1:0]       o_dbg_data
);

    localparam int DEPTH = 1 << (NB_ADDR - 2);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               cap_we;
    logic               cap_sign;
    logic               cap_err;
    logic [1:0]         cap_width;
    logic [NB_ADDR-1:0] cap_addr;

    logic [NB_DATA-1:0] mem [DEPTH];

    logic               accept;
    logic               req_err;
    logic               sel_we;
    logic               sel_sign;
    logic               sel_err;
    logic [1:0]         sel_width;
    logic [NB_ADDR-1:0] sel_addr;
    logic [NB_DATA-1:0] rd_word;
    logic [3:0]         byte_en;
    logic [NB_DATA-1:0] wdata_lane;
    logic [NB_DATA-1:0] rdata_ext;
    logic [NB_DATA-1:0] rsp_data;

    assign accept  = (state == ST_IDLE) && bus.i_req_valid && !i_rst;
    assign req_err = misalign_err(bus.i_req_width, bus.i_req_addr[1:0]);

    // In IDLE the live request drives the lane logic (store commit, LATENCY=1 load);
    // afterwards the captured request does.
    always_comb begin
        if (state == ST_IDLE) begin
            sel_we    = bus.i_req_we;
            sel_sign  = bus.i_req_sign;
            sel_err   = req_err;
            sel_width = bus.i_req_width;
            sel_addr  = bus.i_req_addr;
        end else begin
            sel_we    = cap_we;
            sel_sign  = cap_sign;
            sel_err   = cap_err;
            sel_width = cap_width;
            sel_addr  = cap_addr;
        end
    end

    assign rd_word  = mem[sel_addr[NB_ADDR-1:2]];
    assign rsp_data = (sel_we || sel_err) ? '0 : rdata_ext;

    mem_lane_align #(
        .NB_DATA (NB_DATA)
    ) u_lane_align (
        .width      (sel_width),
        .addr_lo    (sel_addr[1:0]),
        .sign       (sel_sign),
        .wdata      (bus.i_req_wdata),
        .rword      (rd_word),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    // Stores commit on the accepting edge so any later load sees them.
    always_ff @(posedge clk) begin
        if (accept && bus.i_req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[bus.i_req_addr[NB_ADDR-1:2]][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            cap_we          <= 1'b0;
            cap_sign        <= 1'b0;
            cap_err         <= 1'b0;
            cap_width       <= W_BYTE;
            cap_addr        <= '0;
            bus.o_req_ready <= 1'b1;
            bus.o_rsp_valid <= 1'b0;
            bus.o_rsp_rdata <= '0;
            bus.o_rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.o_rsp_valid <= 1'b0;
                    bus.o_rsp_rdata <= '0;
                    bus.o_rsp_err   <= 1'b0;
                    if (bus.i_req_valid) begin
                        cap_we          <= bus.i_req_we;
                        cap_sign        <= bus.i_req_sign;
                        cap_err         <= req_err;
                        cap_width       <= bus.i_req_width;
                        cap_addr        <= bus.i_req_addr;
                        bus.o_req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state           <= ST_RESP;
                            bus.o_rsp_valid <= 1'b1;
                            bus.o_rsp_rdata <= rsp_data;
                            bus.o_rsp_err   <= req_err;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_W'(LATENCY - 2);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state           <= ST_RESP;
                        bus.o_rsp_valid <= 1'b1;
                        bus.o_rsp_rdata <= rsp_data;
                        bus.o_rsp_err   <= cap_err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    state           <= ST_IDLE;
                    bus.o_req_ready <= 1'b1;
                    bus.o_rsp_valid <= 1'b0;
                    bus.o_rsp_rdata <= '0;
                    bus.o_rsp_err   <= 1'b0;
                end
                default: begin
                    state           <= ST_IDLE;
                    bus.o_req_ready <= 1'b1;
                    bus.o_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Debug reads see the word as it was before a same-edge store.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_dbg_data <= '0;
        end else if (i_dbg_en) begin
            o_dbg_data <= mem[i_dbg_addr];
        end
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the MIPS MEM stage: accepts load/store requests over a valid/ready handshake and answers after a fixed latency.
- Stores use byte/half/word lane enables; loads use lane extraction with sign or zero extension.
- Replaces the raw async RAM behind the MEM stage with a multi-cycle, error-reporting memory model.
- Provides a registered debug read port so the debug unit can dump memory after halt.

Parameters:
- NB_DATA, 32, data word width.
- NB_ADDR, 10, byte-address width (256 words of storage).
- LATENCY, 2, cycles from the accepting edge to the response cycle; legal range >= 1.

Ports:
- clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  responder can accept a request.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  NB_ADDR  byte address.
- i_req_width  in  2  00 byte, 01 half, 10 word, 11 illegal.
- i_req_sign  in  1  1 = sign-extend load, 0 = zero-extend.
- i_req_wdata  in  NB_DATA  store data; the low byte/half is used for narrow stores.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  NB_DATA  load result; 0 for stores and errors.
- o_rsp_err  out  1  misaligned or illegal-width request.
- i_dbg_en  in  1  debug read enable.
- i_dbg_addr  in  NB_ADDR-2  debug word index.
- o_dbg_data  out  NB_DATA  registered debug word.

Behaviour:
- Reset (i_rst=1 at a clk edge):
  - State goes to IDLE.
  - Outputs after reset: o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_dbg_data=0.
  - Storage contents are not cleared; simulation initialises them to 0.
- FSM states IDLE, WAIT, RESP:
  - IDLE: o_req_ready=1. On i_req_valid, the request is accepted at the edge and its fields are captured. Go to RESP if LATENCY=1; otherwise go to WAIT with the counter set to LATENCY-2.
  - WAIT: o_req_ready=0. Decrement the counter each cycle; go to RESP when it reaches 0.
  - RESP: o_rsp_valid=1 for exactly one cycle with rdata/err valid, then return to IDLE.
- Timing:
  - o_rsp_valid is high in the cycle that begins LATENCY edges after the accepting edge.
  - There is no response backpressure.
  - Maximum throughput is one request per LATENCY+1 cycles.
  - i_req_valid while ready=0 is ignored; the requester holds it.
- Error rule:
  - width=11 is an error.
  - A half with addr[0]=1 is an error.
  - A word with addr[1:0]!=0 is an error.
  - An errored store writes nothing. An errored load returns rdata=0, err=1.
- Store:
  - Committed on the accepting edge, so any later load observes it.
  - Little-endian lane select: a byte writes lane addr[1:0] with wdata[7:0]; a half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; a word writes all four lanes.
- Load:
  - Word read at index addr[NB_ADDR-1:2] on the cycle before RESP and registered.
  - Byte/half lanes are extracted per the same lane rule, then extended per the captured sign bit.
- Debug port: when i_dbg_en=1, o_dbg_data <= mem[i_dbg_addr] each edge (1-cycle latency); otherwise it holds.
- Reset mid-operation: a pending response is dropped (no o_rsp_valid). A store already accepted stays committed.
- A store and a debug read of the same word on the same edge: o_dbg_data returns the old word.

Decomposition:
- Shared package mem_pkg: width codes (W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b10), FSM state encoding, and a function computing the misalign error.
- One combinational sub-module, mem_lane_align:
  - Store side: generates the 4-bit byte enable and the shifted write data from width/addr/wdata.
  - Load side: extracts and extends the read word from width/addr/sign.

Test Plan:
- Reset with i_rst=1 for 2 cycles -> o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_dbg_data=0.
- Word store/load:
  - SW 0x10 data 0xDEADBEEF, then LW 0x10 -> o_rsp_rdata=0xDEADBEEF, err=0.
  - o_rsp_valid is high exactly LATENCY cycles after each accept; ready is low in between.
- Narrow loads from word 0xDEADBEEF at 0x10:
  - LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE.
  - LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- Narrow stores:
  - SB 0x11 data 0x12345677 -> LW 0x10 = 0xDEAD77EF.
  - Then SH 0x12 data 0x0000CAFE -> LW 0x10 = 0xCAFE77EF.
- Errors:
  - LH 0x11 -> err=1, rdata=0.
  - SW 0x12 data 0x0 -> err=1, and LW 0x10 is unchanged.
  - Width 11 -> err=1.
- Reset and debug:
  - Assert i_rst during WAIT of LW 0x10 -> no o_rsp_valid, and ready=1 the cycle after release.
  - i_dbg_en=1, i_dbg_addr=4 -> o_dbg_data=0xCAFE77EF one cycle later.
